// File: rtl/amm_write_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | amm_write_master: FIFO-fed Avalon-MM burstless write master (IDLE/RUN).    |
// | Option: define AMM_WM_WORD_COUNT_EN to add the stat_words_written counter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module amm_write_master #(
  parameter int ADDRESSWIDTH   = 28,
  parameter int DATAWIDTH      = 32,
  parameter int FIFODEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]   control_write_base,
  input  logic [ADDRESSWIDTH-1:0]   control_write_length,
  input  logic                      control_go,
  output logic                      control_done,
  input  logic                      user_write_buffer,
  input  logic [DATAWIDTH-1:0]      user_buffer_data,
  output logic                      user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]   master_address,
  output logic                      master_write,
  output logic [DATAWIDTH/8-1:0]    master_byteenable,
  output logic [DATAWIDTH-1:0]      master_writedata,
  input  logic                      master_waitrequest
`ifdef AMM_WM_WORD_COUNT_EN
  ,
  output logic [31:0]               stat_words_written
`endif
);

  localparam int BPW   = DATAWIDTH / 8;
  localparam int DEPTH = 2 ** FIFODEPTH_LOG2;
  localparam logic [ADDRESSWIDTH-1:0]   C_BPW      = ADDRESSWIDTH'(BPW);
  localparam logic [ADDRESSWIDTH-1:0]   C_LEN_MASK = ~(C_BPW - ADDRESSWIDTH'(1));
  localparam logic [FIFODEPTH_LOG2:0]   C_DEPTH    = (FIFODEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFODEPTH_LOG2:0]   C_CNT_ONE  = (FIFODEPTH_LOG2 + 1)'(1);
  localparam logic [FIFODEPTH_LOG2-1:0] C_PTR_ONE  = FIFODEPTH_LOG2'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [DATAWIDTH-1:0]      mem_q [DEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFODEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFODEPTH_LOG2:0]   count_q, count_d;
  logic [ADDRESSWIDTH-1:0]   addr_q, addr_d;
  logic [ADDRESSWIDTH-1:0]   remaining_q, remaining_d;
  logic                      fixed_q, fixed_d;

  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic [ADDRESSWIDTH-1:0]   w_len_trunc;

  assign w_full      = (count_q == C_DEPTH);
  assign w_push      = user_write_buffer & ~w_full;
  assign w_len_trunc = control_write_length & C_LEN_MASK;

  assign master_write      = (state_q == RUN) && (count_q != '0) && (remaining_q != '0);
  assign w_pop             = master_write & ~master_waitrequest;
  assign master_address    = addr_q;
  assign master_byteenable = '1;
  // Show-ahead: head word is read combinationally from the storage array.
  assign master_writedata  = mem_q[rd_ptr_q];
  assign control_done      = (state_q == IDLE);
  assign user_buffer_full  = w_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      fixed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      fixed_q     <= fixed_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= user_buffer_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    fixed_d     = fixed_q;

    if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (control_go) begin
          addr_d      = control_write_base;
          remaining_d = w_len_trunc;
          fixed_d     = control_fixed_location;
          if (w_len_trunc != '0) state_d = RUN;
        end
      end
      RUN: begin
        if (w_pop) begin
          remaining_d = remaining_q - C_BPW;
          if (!fixed_q) addr_d = addr_q + C_BPW;
          if (remaining_q == C_BPW) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AMM_WM_WORD_COUNT_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
    end else if (w_pop) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_words_written = stat_q;
`endif

endmodule
`default_nettype wire

// File: doc/amm_write_master.md
AMM_WRITE_MASTER -- requirements
Module: amm_write_master

Interface
REQ-001 Parameter ADDRESSWIDTH, default 28, SHALL set the address and length width in bits.
REQ-002 Parameter DATAWIDTH, default 32, SHALL set the data width in bits; BPW = DATAWIDTH/8 bytes per word.
REQ-003 Parameter FIFODEPTH_LOG2, default 4, SHALL give FIFO depth 2**FIFODEPTH_LOG2 words.
REQ-004 Ports SHALL be exactly:
clk  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-low reset.
control_fixed_location  in  1  1 = hold the address constant for the whole transfer.
control_write_base  in  ADDRESSWIDTH  start byte address, word aligned.
control_write_length  in  ADDRESSWIDTH  transfer length in bytes.
control_go  in  1  single-cycle start pulse.
control_done  out  1  high while no transfer is outstanding.
user_write_buffer  in  1  push request for user_buffer_data.
user_buffer_data  in  DATAWIDTH  word to push.
user_buffer_full  out  1  FIFO full.
master_address  out  ADDRESSWIDTH  Avalon-MM byte address.
master_write  out  1  Avalon-MM write request.
master_byteenable  out  DATAWIDTH/8  tied all ones.
master_writedata  out  DATAWIDTH  Avalon-MM write data.
master_waitrequest  in  1  slave stall.

Function
REQ-005 The FSM SHALL have two states: IDLE and RUN.
REQ-006 In IDLE, control_go=1 SHALL latch base, length and fixed_location, and SHALL enter RUN on the next edge.
REQ-007 Length SHALL be truncated to a multiple of BPW; a truncated length of 0 SHALL leave the FSM in IDLE.
REQ-008 control_done SHALL be 1 in IDLE and 0 in RUN, deasserting the cycle after an accepted go.
REQ-009 control_go SHALL be ignored while in RUN.
REQ-010 A push SHALL occur when user_write_buffer=1 and user_buffer_full=0, in any state.
REQ-011 A push attempted while full SHALL be dropped without any state change.
REQ-012 user_buffer_full SHALL equal (count == depth), where count is the registered occupancy.
REQ-013 The FIFO SHALL be show-ahead: a word pushed into an empty FIFO SHALL be presented on master_writedata in the next cycle.
REQ-014 master_write SHALL equal RUN AND (count != 0) AND (remaining != 0).
REQ-015 A beat SHALL complete when master_write=1 and master_waitrequest=0.
REQ-016 On a completed beat, the FIFO SHALL pop one word and remaining SHALL decrease by BPW.
REQ-017 On a completed beat, master_address SHALL advance by BPW, or hold if fixed_location is set.
REQ-018 master_address and master_writedata SHALL stay stable while master_write=1 and master_waitrequest=1.
REQ-019 When the final beat completes (remaining becomes 0), the FSM SHALL return to IDLE and control_done SHALL be 1 in the next cycle.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-021 master_address SHALL wrap modulo 2**ADDRESSWIDTH.
REQ-022 Words left in the FIFO after done SHALL be retained for the next transfer.

Reset
REQ-023 When reset=0, the block SHALL asynchronously set: state=IDLE, FIFO empty, count=0, remaining=0, master_address=0, master_write=0, control_done=1, user_buffer_full=0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer and discard all FIFO contents.

Configuration
REQ-025 With macro AMM_WM_WORD_COUNT_EN defined, the block SHALL add output stat_words_written [31:0].
- The counter SHALL clear on reset.
- It SHALL increment on every completed beat.
- It SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Without AMM_WM_WORD_COUNT_EN, neither the port nor the counter SHALL exist, and behaviour SHALL otherwise be identical.

Verification
REQ-027 Push 4 words 0x11..0x44, go with base 0x100, length 16, waitrequest=0 -> writes to 0x100, 0x104, 0x108, 0x10C with data 0x11..0x44; done=1 one cycle after the last beat.
REQ-028 Same stimulus with fixed_location=1 -> all 4 writes go to 0x100.
REQ-029 Hold waitrequest=1 for 3 cycles on beat 2 -> address 0x104 and data 0x22 stay stable, and no words are lost.
REQ-030 Push 17 words into the 16-deep FIFO while in IDLE -> full=1 after the 16th push, the 17th push is dropped, and a length-64 transfer outputs words 1..16.
REQ-031 Go with length 0, and separately with length 3 -> done stays 1 and master_write never asserts.
REQ-032 Drop reset to 0 after 2 of 4 beats -> master_write=0 and done=1 immediately, and the FIFO is empty after reset is released.
